uart_tx_fifo: RTL
=================

# uart_tx_fifo

Transmit-side byte buffer placed directly upstream of `rs232_tx`. It accepts bytes from the system side on a single-cycle write strobe and stores them in a synchronous FIFO. It presents them one at a time to `rs232_tx` over the `tx_req`/`tx_data`/`tx_ack` handshake, so software can queue a burst without waiting out each frame.

## Interface
- `DEPTH`, default 16: FIFO entries. Must be a power of two and at least 2.
- `AW`, default `$clog2(DEPTH)`: pointer width. Derived; not to be overridden.
- `clk` in 1: clock. Same domain as `rs232_tx`.
- `rst` in 1: reset, synchronous, active-high.
- `wr_data` in 8: byte to enqueue.
- `wr_en` in 1: enqueue strobe, one byte per cycle.
- `flush` in 1: synchronous clear of queued bytes and `overflow`.
- `full` out 1: FIFO holds `DEPTH` entries.
- `empty` out 1: FIFO holds 0 entries. The byte in the output register is not counted.
- `level` out AW+1: FIFO entry count, 0..`DEPTH`.
- `overflow` out 1: sticky. Set when a write is dropped.
- `tx_data` out 8: byte offered to `rs232_tx`.
- `tx_req` out 1: request to `rs232_tx`. High while `tx_data` is valid and unacknowledged.
- `tx_ack` in 1: one-cycle pulse from `rs232_tx` marking the end of a frame.

## Operation
- Storage is a circular buffer with wr_ptr/rd_ptr of AW+1 bits, where the MSB is the wrap bit.
  - `full` = (ptr low bits equal) and (MSBs differ).
  - `empty` = pointers equal.
  - `level` = wr_ptr − rd_ptr, computed modulo 2^(AW+1).
- Write:
  - If `wr_en` and not `full` (registered value), store the byte and increment wr_ptr.
  - If `wr_en` and `full`, drop the byte and set `overflow`. This applies even if a pop occurs in the same cycle.
- State machine, with states in `uart_pkg`:
  - IDLE (`tx_req`=0): if not `empty`, pop the head into the `tx_data` register, set `tx_req`=1, and go to SEND.
  - SEND (`tx_req`=1, `tx_data` held constant):
    - On `tx_ack` with FIFO not empty: pop the next byte into `tx_data` on the same edge, keep `tx_req`=1, stay in SEND.
    - On `tx_ack` with FIFO empty: clear `tx_req` and go to IDLE.
  - `tx_ack` in IDLE is ignored.
- Simultaneous write and pop:
  - Both take effect. `level` is unchanged.
  - A write into an empty FIFO cannot be popped in the same cycle, because the pop decision uses registered `empty`.
- `flush`:
  - Sets rd_ptr := wr_ptr and clears `overflow`.
  - A `wr_en` in the same cycle is discarded.
  - The byte already in `tx_data` is not aborted: `tx_req` stays high until `tx_ack`, then the block goes to IDLE.
- Reset values:
  - `tx_req`=0, `tx_data`=8'h00, `overflow`=0.
  - Pointers = 0, so `empty`=1, `full`=0, `level`=0.
  - State = IDLE.
- Reset mid-frame: the queue and held byte are lost. `rs232_tx` shares `rst`, so the two blocks stay consistent.

## Timing
- Write-to-request latency is 2 edges:
  - `wr_en` sampled at edge E into an idle, empty block.
  - `level`=1 after E.
  - `tx_req`=1 and `tx_data` valid after E+1; `level` returns to 0 after E+1.
- Back-to-back frames:
  - `tx_ack` is sampled at edge A.
  - After A, `tx_data` holds the next byte, or `tx_req`=0.
  - `rs232_tx` samples `tx_req` in the cycle after `tx_ack`, so it never re-sends the old byte.
- `full`, `empty`, `level` and `overflow` are registered-state outputs that reflect all writes, pops and flushes of the previous edge.

## Structure
- `uart_pkg` holds:
  - `localparam DATA_W = 8`.
  - `typedef enum logic {IDLE, SEND} fifo_tx_state_t`.
  - Baud-setting constants, shared with `rs232_tx` and the future RX path.
- One sub-module, `sync_fifo`, parameterised on DATA_W/DEPTH. It contains storage, pointers, `full`/`empty`/`level` and flush. It is reusable for the RX buffer.
- `uart_tx_fifo` contains the handshake state machine, the `tx_data` register and `overflow`.

## Test plan
- Single byte: write 8'hA5 to the idle block → `tx_req` rises after 2 edges with `tx_data`=8'hA5. Pulse `tx_ack` → `tx_req`=0 next cycle, `empty`=1.
- Burst: write 8'h01..8'h05 back-to-back → bytes are presented in order 01..05, one per `tx_ack`, and `tx_req` never drops between bytes. Also run against the real `rs232_tx` at baud_setting 2'b10 and decode the line.
- Overflow: with `tx_ack` withheld, write DEPTH+2 bytes → the first byte sits in `tx_data`, `full`=1 and `level`=16. The last byte is dropped and `overflow`=1 (the first byte was popped to `tx_data`, so only the last write finds the FIFO full). Ack everything: 17 bytes come out, and the dropped byte is absent.
- Write on ack: write a byte in the same cycle as `tx_ack` while `level`=1 → `level` stays at 1 and ordering is preserved.
- Flush mid-frame: queue 4 bytes, then `flush` while `tx_req`=1 → `level`=0 and `overflow`=0 next cycle. `tx_data` is unchanged until `tx_ack`, then `tx_req`=0.
- Reset mid-SEND: assert `rst` for 1 cycle → `tx_req`=0, `level`=0, state IDLE. A later write resumes normal operation.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, data width and baud-setting codes
package uart_pkg;
   localparam int DATA_W = 8;
   typedef enum logic {IDLE, SEND} fifo_tx_state_t;
   localparam logic [1:0] BAUD_9600   = 2'b00;
   localparam logic [1:0] BAUD_19200  = 2'b01;
   localparam logic [1:0] BAUD_57600  = 2'b10;
   localparam logic [1:0] BAUD_115200 = 2'b11;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: circular-buffer FIFO with wrap-bit pointers, level and flush
module sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input logic clk,
   input logic rst,
   input logic [DATA_W-1:0] wr_data,
   input logic wr_en,
   input logic rd_en,
   input logic flush,
   output logic [DATA_W-1:0] rd_data,
   output logic full,
   output logic empty,
   output logic [AW:0] level
);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic push, pop;
   assign push = wr_en && !full && !flush;
   assign pop = rd_en && !empty && !flush;
   assign full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign empty = wr_ptr == rd_ptr;
   assign level = wr_ptr - rd_ptr;
   assign rd_data = mem[rd_ptr[AW-1:0]];
   // pointer update; flush snaps the read pointer onto the write pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         rd_ptr <= flush ? wr_ptr : pop ? rd_ptr + (AW+1)'(1) : rd_ptr;
      end
   end
   // storage write, no reset needed on the data array
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte queue feeding rs232_tx over a req/ack handshake
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW = $clog2(DEPTH)
) (
   input logic clk,
   input logic rst,
   input logic [DATA_W-1:0] wr_data,
   input logic wr_en,
   input logic flush,
   output logic full,
   output logic empty,
   output logic [AW:0] level,
   output logic overflow,
   output logic [DATA_W-1:0] tx_data,
   output logic tx_req,
   input logic tx_ack
);
   fifo_tx_state_t state, state_nxt;
   logic pop;
   logic [DATA_W-1:0] head;
   sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk(clk),
      .rst(rst),
      .wr_data(wr_data),
      .wr_en(wr_en),
      .rd_en(pop),
      .flush(flush),
      .rd_data(head),
      .full(full),
      .empty(empty),
      .level(level)
   );
   assign tx_req = state == SEND;
   // pop when idle or when the current frame is acked; flush suppresses the pop
   always_comb begin
      pop = !empty && !flush && (state == IDLE || tx_ack);
      state_nxt = pop ? SEND : tx_ack ? IDLE : state;
   end
   // state, held byte and sticky overflow flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         tx_data <= '0;
         overflow <= 1'b0;
      end else begin
         state <= state_nxt;
         if (pop) tx_data <= head;
         overflow <= flush ? 1'b0 : (overflow || (wr_en && full));
      end
   end
endmodule
